// File: rtl/dmem_arbiter.sv
// Two-master arbiter/sequencer for a word-organised data memory with byte-strobed
// synchronous write and asynchronous read. One registered access in flight at a time.
module dmem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter bit          RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [3:0]        m0_strobe,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [3:0]        m1_strobe,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              mem_we,
  output logic [3:0]        mem_strobe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_last_gnt;
  logic                r_id;
  logic                r_we;
  logic [3:0]          r_strobe;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic                r_m0_rvalid;
  logic                r_m1_rvalid;
  logic [31:0]         r_m0_rdata;
  logic [31:0]         r_m1_rdata;

  logic                w_any;
  logic                w_win;
  logic                w_grant;

  assign w_any   = m0_req | m1_req;
  assign w_grant = (r_state == S_IDLE) && w_any;

  // Winner id: 1 selects master 1. Ties go to the master not granted last (RR) or to master 0.
  always_comb begin
    w_win = 1'b0;
    if (m0_req && m1_req)
      w_win = RR_EN ? ~r_last_gnt : 1'b0;
    else if (m1_req)
      w_win = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_any) w_next = S_ACCESS;
      S_ACCESS: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    mem_we     = 1'b0;
    mem_strobe = '0;
    case (r_state)
      S_IDLE: begin
        m0_gnt = w_grant & ~w_win;
        m1_gnt = w_grant &  w_win;
      end
      S_ACCESS: begin
        mem_we     = r_we;
        mem_strobe = r_we ? r_strobe : 4'b0000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt  <= 1'b1;
      r_id        <= 1'b0;
      r_we        <= 1'b0;
      r_strobe    <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      if (w_grant) begin
        r_last_gnt <= w_win;
        r_id       <= w_win;
        r_we       <= w_win ? m1_we     : m0_we;
        r_strobe   <= w_win ? m1_strobe : m0_strobe;
        r_addr     <= w_win ? m1_addr   : m0_addr;
        r_wdata    <= w_win ? m1_wdata  : m0_wdata;
      end
      // Response is registered at the end of ACCESS so it appears in the following (IDLE) cycle.
      if (r_state == S_ACCESS) begin
        if (r_id) begin
          r_m1_rvalid <= 1'b1;
          r_m1_rdata  <= r_we ? 32'h0 : mem_rdata;
        end else begin
          r_m0_rvalid <= 1'b1;
          r_m0_rdata  <= r_we ? 32'h0 : mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign m0_rvalid = r_m0_rvalid;
  assign m1_rvalid = r_m1_rvalid;
  assign m0_rdata  = r_m0_rdata;
  assign m1_rdata  = r_m1_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: round-robin instance backed by a byte-strobed memory model,
// plus a fixed-priority instance observed during the arbitration sequence.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_req = 1'b0, m0_we = 1'b0;
  logic [3:0]  m0_strobe = '0;
  logic [31:0] m0_addr = '0, m0_wdata = '0;
  logic        m1_req = 1'b0, m1_we = 1'b0;
  logic [3:0]  m1_strobe = '0;
  logic [31:0] m1_addr = '0, m1_wdata = '0;

  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [3:0]  mem_strobe;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        p_m0_gnt, p_m0_rvalid, p_m1_gnt, p_m1_rvalid;
  logic [31:0] p_m0_rdata, p_m1_rdata;
  logic        p_mem_we;
  logic [3:0]  p_mem_strobe;
  logic [31:0] p_mem_addr, p_mem_wdata;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_strobe[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  dmem_arbiter #(.ADDR_W(32), .RR_EN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_strobe(m0_strobe), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_strobe(m1_strobe), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_we(mem_we), .mem_strobe(mem_strobe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(32), .RR_EN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_strobe(m0_strobe), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(p_m0_gnt), .m0_rvalid(p_m0_rvalid), .m0_rdata(p_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_strobe(m1_strobe), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(p_m1_gnt), .m1_rvalid(p_m1_rvalid), .m1_rdata(p_m1_rdata),
    .mem_we(p_mem_we), .mem_strobe(p_mem_strobe), .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata),
    .mem_rdata(32'h0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit m, input bit we, input logic [3:0] stb,
                       input logic [31:0] addr, input logic [31:0] wd);
    if (!m) begin
      m0_req = 1'b1; m0_we = we; m0_strobe = stb; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_strobe = stb; m1_addr = addr; m1_wdata = wd;
    end
  endtask

  // Single uncontended access: grant at T, memory cycle at T+1, response at T+2.
  task automatic access(input string tag, input bit m, input bit we, input logic [3:0] stb,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd);
    @(posedge clk); #1;
    drive(m, we, stb, addr, wd);
    #1;
    check({tag, ".gnt"},   {31'b0, (m ? m1_gnt : m0_gnt)}, 32'd1);
    check({tag, ".ogn"},   {31'b0, (m ? m0_gnt : m1_gnt)}, 32'd0);
    @(posedge clk); #1;
    m0_req = 1'b0; m1_req = 1'b0;
    m0_wdata = 32'h0BAD0BAD; m1_wdata = 32'h0BAD0BAD; m0_addr = 32'hFC; m1_addr = 32'hFC;
    #1;
    check({tag, ".we"},    {31'b0, mem_we}, {31'b0, we});
    check({tag, ".addr"},  mem_addr, addr);
    check({tag, ".stb"},   {28'b0, mem_strobe}, {28'b0, (we ? stb : 4'b0000)});
    check({tag, ".gidle"}, {30'b0, m0_gnt, m1_gnt}, 32'd0);
    if (we) check({tag, ".wd"}, mem_wdata, wd);
    @(posedge clk); #1;
    check({tag, ".rv"},    {31'b0, (m ? m1_rvalid : m0_rvalid)}, 32'd1);
    check({tag, ".rd"},    (m ? m1_rdata : m0_rdata), exp_rd);
    check({tag, ".mwe"},   {31'b0, mem_we}, 32'd0);
  endtask

  logic [7:0] exp_rr0, exp_rr1, exp_fp0;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[8]  = 32'hCAFE0001;
    mem[12] = 32'h30303030;

    // Reset state
    #12;
    check("rst.gnt",    {30'b0, m0_gnt, m1_gnt}, 32'd0);
    check("rst.rv",     {30'b0, m0_rvalid, m1_rvalid}, 32'd0);
    check("rst.we",     {31'b0, mem_we}, 32'd0);
    check("rst.stb",    {28'b0, mem_strobe}, 32'd0);
    check("rst.addr",   mem_addr, 32'd0);
    check("rst.wdata",  mem_wdata, 32'd0);
    check("rst.rd0",    m0_rdata, 32'd0);
    check("rst.rd1",    m1_rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Both masters hold requests: RR alternates m0,m1 every 2 cycles; fixed priority always m0.
    exp_rr0 = 8'b0001_0001;
    exp_rr1 = 8'b0100_0100;
    exp_fp0 = 8'b0101_0101;
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0;
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("arb.rr.m0.c%0d", c), {31'b0, m0_gnt},   {31'b0, exp_rr0[c]});
      check($sformatf("arb.rr.m1.c%0d", c), {31'b0, m1_gnt},   {31'b0, exp_rr1[c]});
      check($sformatf("arb.fp.m0.c%0d", c), {31'b0, p_m0_gnt}, {31'b0, exp_fp0[c]});
      check($sformatf("arb.fp.m1.c%0d", c), {31'b0, p_m1_gnt}, 32'd0);
      @(posedge clk); #1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;

    // Full word write then readback; byte write; zero-strobe write
    access("t1.wr", 1'b0, 1'b1, 4'hF,    32'h10, 32'hDEADBEEF, 32'h0);
    access("t1.rd", 1'b0, 1'b0, 4'hF,    32'h10, 32'h0,        32'hDEADBEEF);
    access("t2.wr", 1'b0, 1'b1, 4'b0010, 32'h10, 32'h0000AB00, 32'h0);
    access("t2.rd", 1'b0, 1'b0, 4'hF,    32'h10, 32'h0,        32'hDEADABEF);
    access("t6.wr", 1'b0, 1'b1, 4'h0,    32'h10, 32'h12345678, 32'h0);
    access("t6.rd", 1'b0, 1'b0, 4'hF,    32'h10, 32'h0,        32'hDEADABEF);

    // Contention on 0x20: last grant was m0, so m1's read wins and sees the old word
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 4'hF, 32'h20, 32'hA5A5A5A5);
    drive(1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
    #1;
    check("t4.m1gnt", {31'b0, m1_gnt}, 32'd1);
    check("t4.m0wait", {31'b0, m0_gnt}, 32'd0);
    @(posedge clk); #1;
    m1_req = 1'b0;
    #1;
    check("t4.acc.m0gnt", {31'b0, m0_gnt}, 32'd0);
    check("t4.acc.we",    {31'b0, mem_we}, 32'd0);
    check("t4.acc.addr",  mem_addr, 32'h20);
    @(posedge clk); #1;
    check("t4.m1rv",   {31'b0, m1_rvalid}, 32'd1);
    check("t4.m1rd",   m1_rdata, 32'hCAFE0001);
    check("t4.m0rv",   {31'b0, m0_rvalid}, 32'd0);
    check("t4.m0hold", m0_rdata, 32'hDEADABEF);
    check("t4.m0gnt",  {31'b0, m0_gnt}, 32'd1);
    @(posedge clk); #1;
    m0_req = 1'b0;
    #1;
    check("t4.wr.we",  {31'b0, mem_we}, 32'd1);
    check("t4.wr.wd",  mem_wdata, 32'hA5A5A5A5);
    @(posedge clk); #1;
    check("t4.wr.rv",  {31'b0, m0_rvalid}, 32'd1);
    check("t4.wr.rd",  m0_rdata, 32'h0);
    check("t4.m1rv0",  {31'b0, m1_rvalid}, 32'd0);
    check("t4.m1hold", m1_rdata, 32'hCAFE0001);
    access("t4.rd", 1'b0, 1'b0, 4'hF, 32'h20, 32'h0, 32'hA5A5A5A5);

    // Async reset during the ACCESS cycle of a write to 0x30
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 4'hF, 32'h30, 32'h55555555);
    #1;
    check("t5.gnt", {31'b0, m0_gnt}, 32'd1);
    @(posedge clk); #1;
    m0_req = 1'b0;
    check("t5.we1", {31'b0, mem_we}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5.we0",  {31'b0, mem_we}, 32'd0);
    check("t5.stb0", {28'b0, mem_strobe}, 32'd0);
    @(posedge clk); #1;
    check("t5.rv0",  {31'b0, m0_rvalid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t5.rv1",  {31'b0, m0_rvalid}, 32'd0);
    check("t5.rd0",  m0_rdata, 32'h0);
    access("t5.rd", 1'b0, 1'b0, 4'hF, 32'h30, 32'h0, 32'h30303030);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
